// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller: drives the clk_gating enable, drops it after a
// programmable idle run and restores it with a settle window before reporting ready.
module clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        cfg_auto,
   input  logic        activity,
   input  logic        wake_req,
   output logic        gate_en,
   output logic        clk_ready,
   output logic        gated,
   output logic [15:0] gate_cnt
);

   typedef enum logic [1:0] {
      ST_WAKE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GATED = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] idle_cnt;
   logic [CNT_W-1:0] wake_cnt;
   logic             wake;
   logic             idle;

   assign wake = ~cfg_auto | activity | wake_req;
   assign idle = ~wake;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_WAKE;
      end else begin
         state <= state_next;
      end
   end

   // A wake sequence always runs to completion; inputs are only looked at in RUN, DRAIN and GATED.
   always_comb begin
      state_next = state;
      case (state)
         ST_WAKE: begin
            if (wake_cnt == WAKE_LAST) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (idle && (idle_cnt == IDLE_LAST)) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_next = wake ? ST_RUN : ST_GATED;
         end
         ST_GATED: begin
            if (wake) begin
               state_next = ST_WAKE;
            end
         end
         default: state_next = ST_WAKE;
      endcase
   end

   // Outputs depend only on the state register, so gate_en changes only at clk_in edges.
   always_comb begin
      gate_en   = 1'b1;
      clk_ready = 1'b0;
      gated     = 1'b0;
      case (state)
         ST_WAKE:  begin
            gate_en   = 1'b1;
            clk_ready = 1'b0;
         end
         ST_RUN:   begin
            gate_en   = 1'b1;
            clk_ready = 1'b1;
         end
         ST_DRAIN: begin
            gate_en   = 1'b1;
            clk_ready = 1'b0;
         end
         ST_GATED: begin
            gate_en   = 1'b0;
            gated     = 1'b1;
         end
         default:  begin
            gate_en   = 1'b1;
            clk_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if ((state == ST_RUN) && idle && (idle_cnt != IDLE_LAST)) begin
         idle_cnt <= idle_cnt + 1'b1;
      end else begin
         idle_cnt <= '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wake_cnt <= '0;
      end else if ((state == ST_WAKE) && (wake_cnt != WAKE_LAST)) begin
         wake_cnt <= wake_cnt + 1'b1;
      end else begin
         wake_cnt <= '0;
      end
   end

   // Counts completed DRAIN->GATED transitions; sticks at all-ones until reset.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt <= '0;
      end else if ((state == ST_DRAIN) && !wake && (gate_cnt != 16'hFFFF)) begin
         gate_cnt <= gate_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_clk_gate_ctrl;

   logic        clk_in;
   logic        rst_n;
   logic        cfg_auto;
   logic        activity;
   logic        wake_req;
   logic        gate_en;
   logic        clk_ready;
   logic        gated;
   logic [15:0] gate_cnt;

   int errors = 0;
   int checks = 0;

   clk_gate_ctrl #(
      .IDLE_CYCLES(4),
      .WAKE_CYCLES(2),
      .CNT_W      (8)
   ) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .cfg_auto (cfg_auto),
      .activity (activity),
      .wake_req (wake_req),
      .gate_en  (gate_en),
      .clk_ready(clk_ready),
      .gated    (gated),
      .gate_cnt (gate_cnt)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic c, input logic a, input logic w);
      cfg_auto = c;
      activity = a;
      wake_req = w;
   endtask

   task automatic checkOutput(input string tag, input logic exp_ge, input logic exp_rdy,
                              input logic exp_gt, input logic [15:0] exp_cnt);
      checks++;
      assert ({gate_en, clk_ready, gated, gate_cnt} === {exp_ge, exp_rdy, exp_gt, exp_cnt})
      else begin
         errors++;
         $error("[TB] FAIL %s: got ge=%0b rdy=%0b gt=%0b cnt=%0d, expected ge=%0b rdy=%0b gt=%0b cnt=%0d",
                tag, gate_en, clk_ready, gated, gate_cnt, exp_ge, exp_rdy, exp_gt, exp_cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      #2;
      checkOutput("reset", 1'b1, 1'b0, 1'b0, 16'd0);

      // Release reset just after an edge; ready must follow two edges later.
      tick(1);
      rst_n = 1'b1;
      tick(1);
      checkOutput("wake_edge1", 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      checkOutput("wake_edge2_ready", 1'b1, 1'b1, 1'b0, 16'd0);
      tick(3);
      checkOutput("run_busy", 1'b1, 1'b1, 1'b0, 16'd0);

      // Four idle edges reach DRAIN, the fifth gates.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(3);
      checkOutput("idle3_still_run", 1'b1, 1'b1, 1'b0, 16'd0);
      tick(1);
      checkOutput("idle4_drain", 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      checkOutput("idle5_gated", 1'b0, 1'b0, 1'b1, 16'd1);
      tick(3);
      checkOutput("gated_hold", 1'b0, 1'b0, 1'b1, 16'd1);

      // One-cycle wake_req pulse from GATED.
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick(1);
      checkOutput("wakereq_enable", 1'b1, 1'b0, 1'b0, 16'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("wakereq_settle", 1'b1, 1'b0, 1'b0, 16'd1);
      tick(1);
      checkOutput("wakereq_ready", 1'b1, 1'b1, 1'b0, 16'd1);

      // Activity blip after three idle edges restarts the count.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(3);
      checkOutput("restart_idle3", 1'b1, 1'b1, 1'b0, 16'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("restart_blip", 1'b1, 1'b1, 1'b0, 16'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(3);
      checkOutput("restart_idle3b", 1'b1, 1'b1, 1'b0, 16'd1);
      tick(1);
      checkOutput("restart_drain", 1'b1, 1'b0, 1'b0, 16'd1);

      // Activity seen in DRAIN aborts the gating.
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("drain_abort", 1'b1, 1'b1, 1'b0, 16'd1);
      tick(2);
      checkOutput("drain_abort_hold", 1'b1, 1'b1, 1'b0, 16'd1);

      // Gate again, then force the clock on with cfg_auto=0.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(4);
      checkOutput("regate_drain", 1'b1, 1'b0, 1'b0, 16'd1);
      tick(1);
      checkOutput("regate_gated", 1'b0, 1'b0, 1'b1, 16'd2);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(1);
      checkOutput("forceon_wake", 1'b1, 1'b0, 1'b0, 16'd2);
      tick(1);
      checkOutput("forceon_settle", 1'b1, 1'b0, 1'b0, 16'd2);
      tick(1);
      checkOutput("forceon_ready", 1'b1, 1'b1, 1'b0, 16'd2);
      tick(20);
      checkOutput("forceon_hold", 1'b1, 1'b1, 1'b0, 16'd2);

      // Gate once more, wake, and hit reset one edge into WAKE.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(5);
      checkOutput("third_gate", 1'b0, 1'b0, 1'b1, 16'd3);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("third_wake", 1'b1, 1'b0, 1'b0, 16'd3);
      tick(1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_midwake", 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      checkOutput("rerelease_edge1", 1'b1, 1'b0, 1'b0, 16'd0);
      tick(1);
      checkOutput("rerelease_ready", 1'b1, 1'b1, 1'b0, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
